fence_flush_ctrl: RTL and testbench
===================================

Name: fence_flush_ctrl

Overview:
- Sequences FENCE, FENCE.I and SFENCE.VMA once the commit stage holds one at the head of the scoreboard.
- Waits for the store buffer to drain, runs the D$ and I$ flush handshakes, pulses the TLB flush, then acks commit and requests a pipeline flush with a resume PC.
- Also serves external D$ flush requests on the same resource.
- Sits between commit_stage, the cache subsystem and the MMU; replaces the combinational no_st_pending gating.

Parameters:
- VLEN, 64, virtual address width of PC.
- DCACHE_WB, 1, 1 = write-back D$: FENCE and FENCE.I must flush D$; 0 = skip the D$ flush.
- CNT_W, 32, width of the busy-cycle performance counter.

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- fence_req_i  in  1  head instr is an un-dropped fence-class op; held until fence_done_o.
- fence_type_i  in  2  00 FENCE, 01 FENCE_I, 10 SFENCE_VMA, 11 reserved (treated as FENCE).
- pc_i  in  VLEN  PC of head instr.
- halt_i  in  1  blocks starting a new sequence.
- ext_flush_i  in  1  external D$ flush request (pulse or level).
- no_st_pending_i  in  1  store buffer empty.
- flush_dcache_o  out  1  D$ flush request, level.
- flush_dcache_ack_i  in  1  D$ flush complete.
- flush_icache_o  out  1  I$ flush request, level.
- flush_icache_ack_i  in  1  I$ flush complete.
- sfence_vma_o  out  1  TLB flush, 1-cycle pulse.
- fence_done_o  out  1  1-cycle commit ack.
- ext_flush_ack_o  out  1  1-cycle ack for the external flush.
- flush_pipeline_o  out  1  1-cycle pipeline flush request.
- resume_pc_o  out  VLEN  restart PC; valid with flush_pipeline_o.
- busy_o  out  1  state != IDLE.
- busy_cycles_o  out  CNT_W  saturating count of busy cycles.

Behaviour:
- Reset:
  - State IDLE; all outputs 0, including resume_pc_o and busy_cycles_o.
  - ext_pend cleared; latched type and PC cleared.
  - Reset mid-sequence drops all requests immediately; no ack is emitted.
- States: IDLE, DRAIN, FLUSH_D, FLUSH_I, DONE.
- IDLE:
  - fence_req_i && !halt_i → latch type and pc_i; go to DRAIN.
  - Otherwise ext_pend && !halt_i → latch type = EXT; go to DRAIN.
  - fence_req_i wins over ext_pend when both are present.
- ext_pend:
  - Set on ext_flush_i in any state.
  - Cleared in the cycle its sequence leaves IDLE.
- DRAIN:
  - Stay while !no_st_pending_i.
  - When drained, select the next state from the latched type:
    - FENCE with DCACHE_WB → FLUSH_D.
    - FENCE without DCACHE_WB → DONE.
    - FENCE_I → FLUSH_D if DCACHE_WB, else FLUSH_I.
    - SFENCE_VMA → DONE.
    - EXT → FLUSH_D if DCACHE_WB, else DONE.
  - fence_req_i deasserted while in DRAIN on a non-EXT sequence → abort to IDLE; no outputs.
- FLUSH_D:
  - flush_dcache_o = 1.
  - flush_dcache_ack_i in the same cycle → next state: FLUSH_I for FENCE_I, else DONE.
  - flush_dcache_o drops the next cycle.
  - Ack outside FLUSH_D is ignored.
- FLUSH_I:
  - flush_icache_o = 1 until flush_icache_ack_i; then DONE.
- Abort during FLUSH_D/FLUSH_I:
  - The cache handshake completes regardless.
  - Afterwards go to IDLE with no done, flush or sfence pulses.
- DONE, exactly one cycle, then IDLE:
  - Fence types:
    - fence_done_o = 1 and flush_pipeline_o = 1.
    - resume_pc_o = latched PC + 4, modulo 2^VLEN (wraps).
    - sfence_vma_o = 1 for SFENCE_VMA only.
  - EXT: ext_flush_ack_o = 1 only; no pipeline flush.
- Minimum latency, FENCE with drained stores and WB D$:
  - req at cycle 0 → DRAIN at 1, FLUSH_D at 2.
  - Ack at 2 → DONE at 3.
- halt_i affects only the IDLE exit; an in-flight sequence completes.
- busy_cycles_o increments every cycle busy_o = 1 and saturates at all-ones.

Decomposition:
- Shared package (ariane_pkg-style):
  - fence_type_e enum (FENCE, FENCE_I, SFENCE_VMA, EXT).
  - fence_state_e.
  - Constant INSTR_BYTES = 4.
- Single file, no sub-module.
- The saturating counter is inline; factor it out as sat_counter only if one already exists.

Test Plan:
- FENCE, DCACHE_WB=1, no_st_pending_i low for 5 cycles, D$ ack 3 cycles after flush_dcache_o rises → fence_done_o, flush_pipeline_o single pulse; pc_i=0x8000_0000 gives resume_pc_o=0x8000_0004; busy_cycles_o=10.
- FENCE_I, DCACHE_WB=1 → flush_dcache_o then flush_icache_o, never overlapping; done only after I$ ack; sfence_vma_o stays 0.
- SFENCE_VMA with stores drained, pc_i=0xFFFF_FFFF_FFFF_FFFC → sfence_vma_o, fence_done_o, flush_pipeline_o together at cycle 2; resume_pc_o=0.
- ext_flush_i pulse while a FENCE sequence is busy → after fence done, one extra DRAIN/FLUSH_D sequence; ext_flush_ack_o pulses once; fence_done_o and flush_pipeline_o stay 0.
- fence_req_i dropped in DRAIN → IDLE next cycle, no pulses. Dropped in FLUSH_D → flush_dcache_o held until ack, then IDLE, no pulses.
- rst_ni asserted in FLUSH_I → flush_icache_o 0 immediately; halt_i=1 with fence_req_i=1 → stays IDLE.

Source files
------------

// File: rtl/fence_flush_ctrl_pkg.sv
// Shared types for the fence/flush sequencer.
// Fence classes, sequencer states and next-state helpers.
package fence_flush_ctrl_pkg;

    localparam int unsigned INSTR_BYTES = 4;

    // FT_EXT reuses the reserved commit code point; it is only ever
    // produced internally when an external D$ flush is being served.
    typedef enum logic [1:0] {
        FT_FENCE      = 2'b00,
        FT_FENCE_I    = 2'b01,
        FT_SFENCE_VMA = 2'b10,
        FT_EXT        = 2'b11
    } fence_type_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DRAIN   = 3'd1,
        ST_FLUSH_D = 3'd2,
        ST_FLUSH_I = 3'd3,
        ST_DONE    = 3'd4
    } fence_state_e;

    // Raw commit encoding to internal class; reserved behaves as FENCE.
    function automatic fence_type_e decode_type(
        input logic [1:0] raw
    );
        fence_type_e t;
        case (raw)
            2'b01:   t = FT_FENCE_I;
            2'b10:   t = FT_SFENCE_VMA;
            default: t = FT_FENCE;
        endcase
        return t;
    endfunction

    // Where a sequence goes once the store buffer is empty.
    function automatic fence_state_e drain_next(
        input fence_type_e t,
        input logic        wb_dcache
    );
        fence_state_e s;
        case (t)
            FT_FENCE_I:    s = wb_dcache ? ST_FLUSH_D : ST_FLUSH_I;
            FT_SFENCE_VMA: s = ST_DONE;
            default:       s = wb_dcache ? ST_FLUSH_D : ST_DONE;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/fence_flush_ctrl.sv
// Fence / FENCE.I / SFENCE.VMA sequencer between commit, caches and MMU.
// Ports: commit request (fence_req_i/type/pc, halt_i), external D$ flush
//   (ext_flush_i/ext_flush_ack_o), store-buffer status, D$/I$ flush
//   level handshakes, TLB flush pulse, commit ack, pipeline flush with
//   resume PC, busy flag and saturating busy-cycle counter.
import fence_flush_ctrl_pkg::*;

module fence_flush_ctrl #(
    parameter int unsigned VLEN      = 64,
    parameter bit          DCACHE_WB = 1'b1,
    parameter int unsigned CNT_W     = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             fence_req_i,
    input  logic [1:0]       fence_type_i,
    input  logic [VLEN-1:0]  pc_i,
    input  logic             halt_i,
    input  logic             ext_flush_i,
    input  logic             no_st_pending_i,
    output logic             flush_dcache_o,
    input  logic             flush_dcache_ack_i,
    output logic             flush_icache_o,
    input  logic             flush_icache_ack_i,
    output logic             sfence_vma_o,
    output logic             fence_done_o,
    output logic             ext_flush_ack_o,
    output logic             flush_pipeline_o,
    output logic [VLEN-1:0]  resume_pc_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] busy_cycles_o
);

    fence_state_e    state_q;
    fence_state_e    state_d;
    fence_type_e     type_q;
    logic [VLEN-1:0] pc_q;
    logic            ext_pend_q;
    logic            abort_q;

    logic is_fence;
    logic abort_now;
    logic aborting;
    logic start_seq;
    logic enter_done;
    logic in_flush;

    assign is_fence   = (type_q != FT_EXT);
    // Commit withdrew the instruction; external flushes cannot abort.
    assign abort_now  = is_fence && !fence_req_i;
    // An abort seen mid-handshake is remembered until the ack arrives.
    assign aborting   = abort_q || abort_now;
    assign start_seq  = (state_q == ST_IDLE) && (state_d == ST_DRAIN);
    assign enter_done = (state_d == ST_DONE);
    assign in_flush   = (state_q == ST_FLUSH_D) ||
                        (state_q == ST_FLUSH_I);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!halt_i && (fence_req_i || ext_pend_q))
                    state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (abort_now)
                    state_d = ST_IDLE;
                else if (no_st_pending_i)
                    state_d = drain_next(type_q, DCACHE_WB);
            end
            ST_FLUSH_D: begin
                if (flush_dcache_ack_i) begin
                    if (aborting)
                        state_d = ST_IDLE;
                    else if (type_q == FT_FENCE_I)
                        state_d = ST_FLUSH_I;
                    else
                        state_d = ST_DONE;
                end
            end
            ST_FLUSH_I: begin
                if (flush_icache_ack_i)
                    state_d = aborting ? ST_IDLE : ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so each one is
    // aligned with the state it belongs to.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q          <= ST_IDLE;
            type_q           <= FT_FENCE;
            pc_q             <= '0;
            ext_pend_q       <= 1'b0;
            abort_q          <= 1'b0;
            busy_o           <= 1'b0;
            flush_dcache_o   <= 1'b0;
            flush_icache_o   <= 1'b0;
            sfence_vma_o     <= 1'b0;
            fence_done_o     <= 1'b0;
            ext_flush_ack_o  <= 1'b0;
            flush_pipeline_o <= 1'b0;
            resume_pc_o      <= '0;
            busy_cycles_o    <= '0;
        end else begin
            state_q        <= state_d;
            busy_o         <= (state_d != ST_IDLE);
            flush_dcache_o <= (state_d == ST_FLUSH_D);
            flush_icache_o <= (state_d == ST_FLUSH_I);

            fence_done_o     <= enter_done && is_fence;
            flush_pipeline_o <= enter_done && is_fence;
            ext_flush_ack_o  <= enter_done && !is_fence;
            sfence_vma_o     <= enter_done &&
                                (type_q == FT_SFENCE_VMA);
            if (enter_done && is_fence)
                resume_pc_o <= pc_q + VLEN'(INSTR_BYTES);

            if (ext_flush_i)
                ext_pend_q <= 1'b1;

            if (start_seq) begin
                abort_q <= 1'b0;
                if (fence_req_i) begin
                    type_q <= decode_type(fence_type_i);
                    pc_q   <= pc_i;
                end else begin
                    type_q     <= FT_EXT;
                    ext_pend_q <= 1'b0;
                end
            end else if (in_flush && abort_now) begin
                abort_q <= 1'b1;
            end

            if (busy_o && !(&busy_cycles_o))
                busy_cycles_o <= busy_cycles_o + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fence_flush_ctrl.sv
// Scoreboard bench for fence_flush_ctrl.
// Random fence/ext sequences with a reactive cache/store-buffer driver.
module tb_fence_flush_ctrl;

    localparam int VLEN  = 64;
    localparam int CNT_W = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic            clk;
    logic            rst_n;
    logic            fence_req;
    logic [1:0]      fence_type;
    logic [VLEN-1:0] pc_in;
    logic            halt;
    logic            ext_flush;
    logic            no_st;
    logic            dack;
    logic            iack;
    logic            flush_dcache_o;
    logic            flush_icache_o;
    logic            sfence_vma_o;
    logic            fence_done_o;
    logic            ext_flush_ack_o;
    logic            flush_pipeline_o;
    logic [VLEN-1:0] resume_pc_o;
    logic            busy_o;
    logic [CNT_W-1:0] busy_cycles_o;

    fence_flush_ctrl #(
        .VLEN(VLEN),
        .DCACHE_WB(1'b1),
        .CNT_W(CNT_W)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .fence_req_i(fence_req),
        .fence_type_i(fence_type),
        .pc_i(pc_in),
        .halt_i(halt),
        .ext_flush_i(ext_flush),
        .no_st_pending_i(no_st),
        .flush_dcache_o(flush_dcache_o),
        .flush_dcache_ack_i(dack),
        .flush_icache_o(flush_icache_o),
        .flush_icache_ack_i(iack),
        .sfence_vma_o(sfence_vma_o),
        .fence_done_o(fence_done_o),
        .ext_flush_ack_o(ext_flush_ack_o),
        .flush_pipeline_o(flush_pipeline_o),
        .resume_pc_o(resume_pc_o),
        .busy_o(busy_o),
        .busy_cycles_o(busy_cycles_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit              ext;
        bit              sf;
        logic [VLEN-1:0] pc;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   busy_model = 0;
    bit   mon_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    // Monitor: every completion pulse consumes one scoreboard entry.
    exp_t e;
    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            if (flush_dcache_o || flush_icache_o)
                chk("cache_overlap",
                    64'(flush_dcache_o && flush_icache_o), 64'd0);
            if (fence_done_o || flush_pipeline_o ||
                sfence_vma_o || ext_flush_ack_o) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_pulse got=%b%b%b%b want=none",
                             fence_done_o, flush_pipeline_o,
                             sfence_vma_o, ext_flush_ack_o);
                end else begin
                    e = exp_q.pop_front();
                    chk("pulse_set",
                        {60'd0, fence_done_o, flush_pipeline_o,
                         sfence_vma_o, ext_flush_ack_o},
                        {60'd0, !e.ext, !e.ext, e.sf, e.ext});
                    if (!e.ext)
                        chk("resume_pc", resume_pc_o, e.pc);
                end
            end
        end
    end

    // Called at the negedge of "cycle 0": the cycle in which the DUT is
    // IDLE and sees the request (or its pending external flush).
    task automatic do_seq(input bit ext, input logic [1:0] ty,
                          input logic [VLEN-1:0] pc, input int d,
                          input int a, input int b, input int mode,
                          input int j, input bit inj);
        int eff;
        int len;
        int k;
        int dcnt;
        int icnt;
        bit need_d;
        bit need_i;
        bit fin;
        eff    = ext ? 3 : ((ty == 2'b11) ? 0 : int'(ty));
        need_d = (eff != 2);
        need_i = (eff == 1);
        if (mode == 0)
            len = (d + 1) + (need_d ? a + 1 : 0) +
                  (need_i ? b + 1 : 0) + 1;
        else if (mode == 1)
            len = j;
        else if (mode == 2)
            len = (d + 1) + (a + 1);
        else
            len = (d + 1) + (a + 1) + (b + 1);
        if (mode == 0)
            exp_q.push_back('{ext, eff == 2, pc + 64'd4});

        fence_req  = !ext;
        fence_type = ty;
        pc_in      = pc;
        halt       = 1'b0;
        ext_flush  = 1'b0;
        no_st      = 1'b0;
        dack       = 1'($urandom_range(0, 1));
        iack       = 1'($urandom_range(0, 1));
        k    = 0;
        dcnt = -1;
        icnt = -1;
        fin  = 1'b0;
        while (!fin) begin
            @(negedge clk);
            k++;
            if (!busy_o) begin
                fin = 1'b1;
            end else if (k > 400) begin
                total++;
                bad++;
                $display("FAIL seq_timeout got=busy want=idle");
                fin = 1'b1;
            end else begin
                no_st     = (k > d);
                halt      = 1'($urandom_range(0, 1));
                ext_flush = inj && (k == 1);
                if (flush_dcache_o) begin
                    dcnt++;
                    dack = (dcnt == a);
                end else begin
                    dcnt = -1;
                    dack = 1'($urandom_range(0, 1));
                end
                if (flush_icache_o) begin
                    icnt++;
                    iack = (icnt == b);
                end else begin
                    icnt = -1;
                    iack = 1'($urandom_range(0, 1));
                end
                if (mode == 1 && k == j) fence_req = 1'b0;
                if (mode == 2 && flush_dcache_o) fence_req = 1'b0;
                if (mode == 3 && flush_icache_o) fence_req = 1'b0;
                if (fence_done_o) fence_req = 1'b0;
            end
        end
        fence_req = 1'b0;
        halt      = 1'b0;
        ext_flush = 1'b0;
        no_st     = 1'b0;
        dack      = 1'b0;
        iack      = 1'b0;
        busy_model += len;
        chk("busy_cycles", 64'(busy_cycles_o), 64'(sat(busy_model)));
    endtask

    task automatic run_txn(input logic [1:0] ty,
                           input logic [VLEN-1:0] pc, input int d,
                           input int a, input int b, input int mode,
                           input int j, input bit inj, input int h);
        if (h > 0) begin
            fence_req  = 1'b1;
            fence_type = ty;
            pc_in      = pc;
            halt       = 1'b1;
            for (int i = 0; i < h; i++) begin
                @(negedge clk);
                chk("halt_hold", 64'(busy_o), 64'd0);
            end
        end
        do_seq(1'b0, ty, pc, d, a, b, mode, j, inj);
        if (inj)
            do_seq(1'b1, 2'b00, '0, $urandom_range(0, 3),
                   $urandom_range(0, 3), 0, 0, 0, 1'b0);
    endtask

    task automatic run_ext(input int d, input int a);
        ext_flush = 1'b1;
        @(negedge clk);
        do_seq(1'b1, 2'b00, '0, d, a, 0, 0, 0, 1'b0);
    endtask

    initial begin
        logic [1:0]      ty;
        logic [VLEN-1:0] pc;
        int d;
        int a;
        int b;
        int mode;
        int j;
        int h;
        int eff;
        int k;
        bit inj;

        fence_req  = 1'b0;
        fence_type = 2'b00;
        pc_in      = '0;
        halt       = 1'b0;
        ext_flush  = 1'b0;
        no_st      = 1'b0;
        dack       = 1'b0;
        iack       = 1'b0;
        rst_n      = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_flush_d", 64'(flush_dcache_o), 64'd0);
        chk("rst_flush_i", 64'(flush_icache_o), 64'd0);
        chk("rst_sfence", 64'(sfence_vma_o), 64'd0);
        chk("rst_done", 64'(fence_done_o), 64'd0);
        chk("rst_ext_ack", 64'(ext_flush_ack_o), 64'd0);
        chk("rst_flush_pipe", 64'(flush_pipeline_o), 64'd0);
        chk("rst_resume_pc", resume_pc_o, 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_busy_cycles", 64'(busy_cycles_o), 64'd0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);

        run_txn(2'b00, 64'h8000_0000, 4, 3, 0, 0, 0, 1'b0, 0);
        chk("first_fence_busy", 64'(busy_cycles_o), 64'd10);
        run_txn(2'b01, 64'h0000_1234, 1, 2, 3, 0, 0, 1'b0, 0);
        run_txn(2'b10, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 0, 0, 0, 1'b0, 0);
        run_txn(2'b00, 64'h0000_2000, 2, 1, 0, 0, 0, 1'b1, 0);
        run_txn(2'b00, 64'h0000_3000, 3, 1, 0, 1, 2, 1'b0, 0);
        run_txn(2'b00, 64'h0000_4000, 0, 2, 0, 2, 0, 1'b0, 0);
        run_txn(2'b01, 64'h0000_5000, 0, 1, 2, 3, 0, 1'b0, 0);
        run_txn(2'b00, 64'h0000_6000, 1, 0, 0, 0, 0, 1'b0, 3);
        run_txn(2'b11, 64'h0000_7000, 0, 0, 0, 0, 0, 1'b0, 0);
        run_ext(1, 1);

        for (int n = 0; n < 80; n++) begin
            ty   = 2'($urandom_range(0, 3));
            pc   = {$urandom, $urandom};
            d    = $urandom_range(0, 4);
            a    = $urandom_range(0, 3);
            b    = $urandom_range(0, 3);
            mode = $urandom_range(0, 3);
            eff  = (ty == 2'b11) ? 0 : int'(ty);
            if (mode == 1 && d == 0) mode = 0;
            if (mode == 2 && eff == 2) mode = 0;
            if (mode == 3 && eff != 1) mode = 0;
            j    = (mode == 1) ? $urandom_range(1, d) : 0;
            inj  = ($urandom_range(0, 3) == 0);
            h    = ($urandom_range(0, 3) == 0) ?
                   $urandom_range(1, 3) : 0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_txn(ty, pc, d, a, b, mode, j, inj, h);
            if ($urandom_range(0, 7) == 0)
                run_ext($urandom_range(0, 3), $urandom_range(0, 3));
        end

        // Reset while in FLUSH_I with an external flush pending.
        fence_req  = 1'b1;
        fence_type = 2'b01;
        pc_in      = 64'h0000_1000;
        no_st      = 1'b1;
        ext_flush  = 1'b1;
        @(negedge clk);
        ext_flush = 1'b0;
        k = 0;
        while (!flush_icache_o && k < 20) begin
            dack = flush_dcache_o;
            iack = 1'b0;
            @(negedge clk);
            k++;
        end
        dack = 1'b0;
        chk("reach_flush_i", 64'(flush_icache_o), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_flush_i", 64'(flush_icache_o), 64'd0);
        chk("mid_rst_busy", 64'(busy_o), 64'd0);
        chk("mid_rst_cycles", 64'(busy_cycles_o), 64'd0);
        chk("mid_rst_resume", resume_pc_o, 64'd0);
        chk("mid_rst_done", 64'(fence_done_o), 64'd0);
        fence_req = 1'b0;
        no_st     = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_idle", 64'(busy_o), 64'd0);
        end

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
